// File: rtl/bbox_msg_reader.sv
// bbox_msg_reader: Avalon-MM master that drains the image processor's message FIFO.
// It polls the status register, reads message words, rebuilds each bounding-box message
// (red, blue, yellow min/max words followed by the ID word) and publishes the boxes.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   enable                poll enable, sampled only while waiting between polls
//   m_*                   Avalon-MM master towards the image processor slave
//   red/blue/yel_min/max  {x[10:0], y[10:0]} box corners, updated together
//   bbox_valid            one-cycle pulse when the box outputs update
//   busy                  high whenever the reader is not waiting between polls
//   sync_err_cnt          saturating sync-error count (only with BBOX_MSG_READER_ERRCNT_EN)
//
// Optional feature: define BBOX_MSG_READER_ERRCNT_EN to add the sync_err_cnt output.
module bbox_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = 32'h47524259,
  parameter int unsigned WORDS_PER_MSG = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [21:0] red_min,
  output logic [21:0] red_max,
  output logic [21:0] blue_min,
  output logic [21:0] blue_max,
  output logic [21:0] yel_min,
  output logic [21:0] yel_max,
  output logic        bbox_valid,
`ifdef BBOX_MSG_READER_ERRCNT_EN
  output logic [7:0]  sync_err_cnt,
`endif
  output logic        busy
);

  localparam int unsigned    CntW      = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(POLL_INTERVAL - 1);
  localparam logic [2:0]     WcntFull  = 3'(WORDS_PER_MSG);

  typedef enum logic [2:0] {
    StInitFlush,
    StPollWait,
    StStatRd,
    StStatCap,
    StMsgRd,
    StMsgCap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   poll_cnt_q;
  logic [7:0]        words_left_q;
  logic [2:0]        wcnt_q;
  logic [21:0]       shadow_q [6];
  logic              id_hit, publish, sync_err;

  assign id_hit   = (m_readdata == MSG_ID);
  assign publish  = (state_q == StMsgCap) && id_hit && (wcnt_q == WcntFull);
  assign sync_err = (state_q == StMsgCap) && id_hit && (wcnt_q != WcntFull);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StInitFlush;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInitFlush: state_d = StPollWait;
      StPollWait:  if (poll_cnt_q == '0 && enable) state_d = StStatRd;
      StStatRd:    state_d = StStatCap;
      StStatCap:   state_d = (m_readdata[15:8] == 8'd0) ? StPollWait : StMsgRd;
      StMsgRd:     state_d = StMsgCap;
      // words_left_q is pre-decrement here: 1 means this was the last word
      StMsgCap:    state_d = (words_left_q <= 8'd1) ? StPollWait : StMsgRd;
      default:     state_d = StInitFlush;
    endcase
  end

  // Bus outputs are Moore decodes of the state, forced idle while reset is held
  always_comb begin
    m_write     = 1'b0;
    m_read      = 1'b0;
    m_address   = 3'd0;
    m_writedata = 32'd0;
    busy        = 1'b0;
    if (!reset) begin
      busy = (state_q != StPollWait);
      unique case (state_q)
        StInitFlush: begin
          m_write     = 1'b1;
          m_writedata = 32'h0000_0010;
        end
        StStatRd: m_read = 1'b1;
        StMsgRd: begin
          m_read    = 1'b1;
          m_address = 3'd1;
        end
        default: ;
      endcase
    end
    m_chipselect = m_read | m_write;
  end

  // Datapath: poll timer, word bookkeeping, shadow and published boxes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q   <= CntReload;
      words_left_q <= 8'd0;
      wcnt_q       <= 3'd0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= 22'd0;
      red_min      <= 22'd0;
      red_max      <= 22'd0;
      blue_min     <= 22'd0;
      blue_max     <= 22'd0;
      yel_min      <= 22'd0;
      yel_max      <= 22'd0;
      bbox_valid   <= 1'b0;
    end else begin
      bbox_valid <= publish;
      if (state_q == StPollWait) begin
        if (poll_cnt_q != '0) poll_cnt_q <= poll_cnt_q - 1'b1;
        else if (enable)      poll_cnt_q <= CntReload;
      end
      if (state_q == StStatCap) words_left_q <= m_readdata[15:8];
      if (state_q == StMsgCap) begin
        words_left_q <= words_left_q - 8'd1;
        if (id_hit) begin
          // Any ID word resynchronises; only a complete message is published
          wcnt_q <= 3'd0;
          if (publish) begin
            red_min  <= shadow_q[0];
            red_max  <= shadow_q[1];
            blue_min <= shadow_q[2];
            blue_max <= shadow_q[3];
            yel_min  <= shadow_q[4];
            yel_max  <= shadow_q[5];
          end
        end else if (wcnt_q < WcntFull) begin
          shadow_q[wcnt_q] <= {m_readdata[26:16], m_readdata[10:0]};
          wcnt_q           <= wcnt_q + 3'd1;
        end else begin
          // Overlong message: drop the word and mark it so the next ID is rejected
          wcnt_q <= 3'd7;
        end
      end
    end
  end

`ifdef BBOX_MSG_READER_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            sync_err_cnt <= 8'd0;
    else if (sync_err && sync_err_cnt != 8'hff) sync_err_cnt <= sync_err_cnt + 8'd1;
  end
`else
  logic unused_sync_err;
  assign unused_sync_err = sync_err;
`endif

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Testbench for bbox_msg_reader: behavioural slave FIFO, message-level reference model,
// scoreboard of expected publications popped by a monitor on every bbox_valid pulse.
`timescale 1ns/1ps
module tb_bbox_msg_reader;

  localparam int unsigned P  = 8;
  localparam logic [31:0] ID = 32'h47524259;

  logic        clk, reset, enable;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata, m_readdata;
  logic [21:0] red_min, red_max, blue_min, blue_max, yel_min, yel_max;
  logic        bbox_valid, busy;
`ifdef BBOX_MSG_READER_ERRCNT_EN
  logic [7:0]  sync_err_cnt;
`endif

  bbox_msg_reader #(
    .POLL_INTERVAL(P),
    .MSG_ID       (ID),
    .WORDS_PER_MSG(6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .m_chipselect(m_chipselect),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_writedata (m_writedata),
    .m_readdata  (m_readdata),
    .red_min     (red_min),
    .red_max     (red_max),
    .blue_min    (blue_min),
    .blue_max    (blue_max),
    .yel_min     (yel_min),
    .yel_max     (yel_max),
    .bbox_valid  (bbox_valid),
`ifdef BBOX_MSG_READER_ERRCNT_EN
    .sync_err_cnt(sync_err_cnt),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0]  fifo  [$];
  logic [131:0] exp_q [$];
  logic [21:0]  pend  [$];
  int           exp_err = 0;
  int           pulses = 0;
  logic [131:0] last_pub = '0;
  logic         prev_read = 1'b0;

  wire [131:0] cur_out = {red_min, red_max, blue_min, blue_max, yel_min, yel_max};

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mk(input logic [10:0] x, input logic [10:0] y);
    return {5'd0, x, 5'd0, y};
  endfunction

  function automatic logic [31:0] rand_coord();
    logic [31:0] w;
    w = $urandom;
    if (w == ID) w = w ^ 32'h1;
    return w;
  endfunction

  // Reference model: a message is the run of non-ID words since the previous ID.
  // Exactly six of them publish; any other count is a sync error.
  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    if (w == ID) begin
      if (pend.size() == 6)
        exp_q.push_back({pend[0], pend[1], pend[2], pend[3], pend[4], pend[5]});
      else if (exp_err < 255)
        exp_err++;
      pend.delete();
    end else begin
      pend.push_back({w[26:16], w[10:0]});
    end
  endtask

  // Slave: status word carries usedw in [15:8]; a message read pops the FIFO.
  initial begin
    m_readdata = 32'd0;
    forever begin
      @(negedge clk);
      if (m_write && m_address == 3'd0 && m_writedata[4]) fifo.delete();
      if (m_read) begin
        if (m_address == 3'd0)     m_readdata = {16'd0, 8'(fifo.size()), 8'd0};
        else if (fifo.size() > 0)  m_readdata = fifo.pop_front();
        else                       m_readdata = 32'h0bad_0bad;
      end
    end
  end

  // Monitor: bus rules every cycle, publications against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", {cur_out, bbox_valid, busy, m_read, m_write, m_chipselect,
                              m_address, m_writedata}, '0);
      last_pub  = '0;
      prev_read = 1'b0;
    end else begin
      check("cs_rule", m_chipselect, m_read | m_write);
      check("rd_wr_excl", m_read & m_write, 1'b0);
      if (!(m_read | m_write)) check("idle_bus", {m_address, m_writedata}, '0);
      check("read_gap", m_read & prev_read, 1'b0);
      prev_read = m_read;
      if (bbox_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_publish", bbox_valid, 1'b0);
        end else begin
          last_pub = exp_q.pop_front();
          check("publish", cur_out, last_pub);
        end
      end else begin
        check("hold", cur_out, last_pub);
      end
    end
  end

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(posedge clk);
      #1;
      if (fifo.size() == 0 && !busy) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got fifo=%0d busy=%0b expected empty/idle", fifo.size(), busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_err();
`ifdef BBOX_MSG_READER_ERRCNT_EN
    check("sync_err_cnt", sync_err_cnt, exp_err);
`endif
  endtask

  initial begin
    int idle, gap, n, cyc, lastc, p0, k, s;
    logic [31:0] msg [$];
    logic [31:0] saved [$];

    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("flush_write", {m_write, m_address, m_writedata}, {1'b1, 3'd0, 32'h10});

    // Exactly P strobe-free cycles before the first status read
    idle = 0;
    for (int t = 0; t < 10 * P; t++) begin
      @(posedge clk);
      #1;
      if (m_read | m_write) break;
      idle++;
    end
    check("first_poll_gap", idle, P);
    check("first_poll_is_status", {m_read, m_address}, {1'b1, 3'd0});

    // Empty FIFO: no message reads, next status read P+2 cycles later
    gap = 0;
    n = 0;
    for (int t = 0; t < 10 * P; t++) begin
      @(posedge clk);
      #1;
      gap++;
      if (m_read && m_address == 3'd1) n++;
      if (m_read && m_address == 3'd0) break;
    end
    check("empty_poll_gap", gap, P + 2);
    check("empty_no_msg_reads", n, 0);

    // One full message
    p0 = pulses;
    msg = {mk(10, 170), mk(50, 190), mk(100, 165), mk(120, 199), mk(300, 161), mk(330, 180), ID};
    foreach (msg[i]) push(msg[i]);
    n = 0;
    cyc = 0;
    lastc = 0;
    for (int t = 0; t < 20 * P && n < 7; t++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_read && m_address == 3'd1) begin
        if (n > 0) check("msg_read_spacing", cyc - lastc, 2);
        lastc = cyc;
        n++;
      end
    end
    check("msg_read_count", n, 7);
    wait_drain();
    check("red_min", red_min, {11'd10, 11'd170});
    check("yel_max", yel_max, {11'd330, 11'd180});
    check("single_pulse", pulses - p0, 1);

    // Message split across polls
    p0 = pulses;
    msg = {mk(20, 100), mk(60, 140), mk(200, 110), mk(220, 150), mk(400, 120), mk(440, 170), ID};
    for (int i = 0; i < 4; i++) push(msg[i]);
    wait_drain();
    check("split_no_early_pulse", pulses - p0, 0);
    for (int i = 4; i < 7; i++) push(msg[i]);
    wait_drain();
    check("split_one_pulse", pulses - p0, 1);

    // Short message then a full one
    p0 = pulses;
    for (int i = 0; i < 3; i++) push(rand_coord());
    push(ID);
    for (int i = 0; i < 6; i++) push(rand_coord());
    push(ID);
    wait_drain();
    check("short_then_full_pulse", pulses - p0, 1);
    check_err();

    // Enable low: no polling once the reader has settled
    enable = 1'b0;
    repeat (P + 10) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) push(rand_coord());
    push(ID);
    n = 0;
    for (int t = 0; t < 3 * P; t++) begin
      @(posedge clk);
      #1;
      if (m_read) n++;
    end
    check("disabled_no_reads", n, 0);
    enable = 1'b1;
    wait_drain();

    // Reset during the 4th message read; the truncated message is not modelled, its
    // tail is re-presented after the flush and must be rejected.
    p0 = pulses;
    for (int i = 0; i < 6; i++) fifo.push_back(rand_coord());
    fifo.push_back(ID);
    n = 0;
    for (int t = 0; t < 20 * P && n < 4; t++) begin
      @(posedge clk);
      #1;
      if (m_read && m_address == 3'd1) n++;
    end
    check("reset_reached_4th_read", n, 4);
    #1 reset = 1'b1;
    pend.delete();
    exp_err = 0;
    #1;
    check("reset_same_cycle", {cur_out, bbox_valid, m_read, m_chipselect, busy}, '0);
    saved = fifo;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("reflush_write", {m_write, m_address, m_writedata}, {1'b1, 3'd0, 32'h10});
    @(posedge clk);
    #1;
    foreach (saved[i]) push(saved[i]);
    wait_drain();
    check("remainder_no_publish", pulses - p0, 0);
    check_err();

    // Randomised traffic
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
        enable = 1'b1;
      end
      k = $urandom_range(0, 3);
      case (k)
        0: begin
          for (int i = 0; i < 6; i++) push(rand_coord());
          push(ID);
        end
        1: begin
          s = $urandom_range(0, 5);
          for (int i = 0; i < s; i++) push(rand_coord());
          push(ID);
        end
        2: begin
          s = $urandom_range(7, 9);
          for (int i = 0; i < s; i++) push(rand_coord());
          push(ID);
        end
        default: begin
          s = $urandom_range(1, 6);
          for (int i = 0; i < s; i++) push(rand_coord());
          repeat ($urandom_range(0, 40)) @(posedge clk);
          #1;
          for (int i = s; i < 6; i++) push(rand_coord());
          push(ID);
        end
      endcase
      wait_drain();
    end

    check("no_pending_publish", exp_q.size(), 0);
    check_err();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
